// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - shared definitions for the PISO/SIPO shift-register family
//
// Purpose: FSM state encodings, default frame width and a counter-width helper
//          shared by the serial transmitter and the serial-in receiver.
// Ports:   none (package)

package shift_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } shift_state_e;

  localparam int DEFAULT_WIDTH = 16;

  // A modulo-1 counter still needs one flop so its ports stay legal.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - modulo-N counter with clear, enable and terminal count
//
// Purpose: counts 0..MODULUS-1 and wraps; clear has priority over enable.
// Ports:
//   clk_i       in   clock, counts on the falling edge
//   reset_i     in   asynchronous active-high reset
//   clear_i     in   force the count to 0 on the next edge
//   enable_i    in   advance the count on the next edge
//   count_o     out  current count
//   terminal_o  out  high while count_o == MODULUS-1

module shift_bit_counter
  import shift_reg_pkg::*;
#(
  parameter int MODULUS = DEFAULT_WIDTH,
  localparam int CW     = cnt_width(MODULUS)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          enable_i,
  output logic [CW-1:0] count_o,
  output logic          terminal_o
);

  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  logic [CW-1:0] count_q;

  assign count_o    = count_q;
  assign terminal_o = (count_q == LAST);

  always_ff @(negedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= terminal_o ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/piso_shift_transmitter.sv
// rtl/piso_shift_transmitter.sv - parallel-in serial-out frame transmitter
//
// Purpose: accepts one DATA_WIDTH-bit word per valid/ready handshake and sends
//          it one bit per falling clock edge, with frame strobes and an
//          optional forced idle gap between frames.
// Ports:
//   Clk_In            in   clock, all flops update on the falling edge
//   Reset_In          in   asynchronous active-high reset
//   Parallel_Data_In  in   word to send, sampled only on an accepted load
//   Load_Valid_In     in   Parallel_Data_In is valid
//   Load_Ready_Out    out  a word can be accepted this cycle
//   Serial_Data_Out   out  current serial bit (0 outside a frame)
//   Serial_Valid_Out  out  Serial_Data_Out carries a frame bit
//   Frame_Start_Out   out  high with the first bit of a frame
//   Frame_End_Out     out  high with the last bit of a frame
//   Busy_Out          out  high while shifting or in the inter-frame gap

module piso_shift_transmitter
  import shift_reg_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH,
  parameter bit LSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  input  logic                  Load_Valid_In,
  output logic                  Load_Ready_Out,
  output logic                  Serial_Data_Out,
  output logic                  Serial_Valid_Out,
  output logic                  Frame_Start_Out,
  output logic                  Frame_End_Out,
  output logic                  Busy_Out
);

  localparam int CW      = cnt_width(DATA_WIDTH);
  localparam int GAP_MOD = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int GW      = cnt_width(GAP_MOD);

  // The counter holds the index of the bit currently on Serial_Data_Out, so the
  // end strobe must be registered while the counter still shows DATA_WIDTH-2.
  localparam logic [CW-1:0] END_CNT = CW'(DATA_WIDTH - 2);

  shift_state_e          state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic                  bit_d;

  logic [CW-1:0]         bit_cnt;
  logic                  bit_tc;
  logic [GW-1:0]         gap_count_unused;
  logic                  gap_tc;
  logic                  last_bit;
  logic                  accept;

  assign last_bit = (state_q == ST_SHIFT) && bit_tc;

  // Back-to-back frames are only possible without a gap: the next word is
  // taken while the last bit of the current one is on the line.
  assign Load_Ready_Out = !Reset_In &&
                          ((state_q == ST_IDLE) || ((GAP_CYCLES == 0) && last_bit));
  assign accept   = Load_Valid_In && Load_Ready_Out;
  assign Busy_Out = (state_q != ST_IDLE);

  shift_bit_counter #(.MODULUS(DATA_WIDTH)) u_bit_counter (
    .clk_i      (Clk_In),
    .reset_i    (Reset_In),
    .clear_i    (accept),
    .enable_i   (state_q == ST_SHIFT),
    .count_o    (bit_cnt),
    .terminal_o (bit_tc)
  );

  shift_bit_counter #(.MODULUS(GAP_MOD)) u_gap_counter (
    .clk_i      (Clk_In),
    .reset_i    (Reset_In),
    .clear_i    (state_q != ST_GAP),
    .enable_i   (state_q == ST_GAP),
    .count_o    (gap_count_unused),
    .terminal_o (gap_tc)
  );

  // On accept the first bit goes straight from the input to the output flop and
  // the shift register keeps only the bits still to be sent.
  always_comb begin
    shift_d = shift_q;
    bit_d   = 1'b0;
    if (accept) begin
      if (LSB_FIRST) begin
        bit_d   = Parallel_Data_In[0];
        shift_d = {1'b0, Parallel_Data_In[DATA_WIDTH-1:1]};
      end else begin
        bit_d   = Parallel_Data_In[DATA_WIDTH-1];
        shift_d = {Parallel_Data_In[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      if (LSB_FIRST) begin
        bit_d   = shift_q[0];
        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
      end else begin
        bit_d   = shift_q[DATA_WIDTH-1];
        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q          <= ST_IDLE;
      shift_q          <= '0;
      Serial_Data_Out  <= 1'b0;
      Serial_Valid_Out <= 1'b0;
      Frame_Start_Out  <= 1'b0;
      Frame_End_Out    <= 1'b0;
    end else begin
      Serial_Data_Out  <= 1'b0;
      Serial_Valid_Out <= 1'b0;
      Frame_Start_Out  <= 1'b0;
      Frame_End_Out    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q          <= ST_SHIFT;
            shift_q          <= shift_d;
            Serial_Data_Out  <= bit_d;
            Serial_Valid_Out <= 1'b1;
            Frame_Start_Out  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!bit_tc) begin
            shift_q          <= shift_d;
            Serial_Data_Out  <= bit_d;
            Serial_Valid_Out <= 1'b1;
            Frame_End_Out    <= (bit_cnt == END_CNT);
          end else if (accept) begin
            shift_q          <= shift_d;
            Serial_Data_Out  <= bit_d;
            Serial_Valid_Out <= 1'b1;
            Frame_Start_Out  <= 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state_q <= ST_GAP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_tc) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
